// File: rtl/coin_pkg.sv
// coin_pkg: coin event codes and weights shared with the downstream vending FSM
package coin_pkg;
    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_A    = 2'b01,
        COIN_B    = 2'b10,
        COIN_JAM  = 2'b11
    } coin_t;
    localparam int COIN_W_A = 1;
    localparam int COIN_W_B = 2;
    function automatic logic [7:0] coin_add(input logic [7:0] tot, input logic [1:0] code);
        logic [8:0] sum;
        sum = {1'b0, tot} + (code == COIN_A ? 9'(COIN_W_A) : code == COIN_B ? 9'(COIN_W_B) : 9'd0);
        return sum[8] ? 8'hff : sum[7:0];
    endfunction
endpackage

// File: rtl/coin_acceptor_if.sv
// coin_acceptor_if: coin event valid/ready handshake toward the vending FSM
interface coin_acceptor_if;
    logic out_valid, out_ready, e1, e2;
    modport master(output out_valid, e1, e2, input out_ready);
    modport slave(input out_valid, e1, e2, output out_ready);
endinterface

// File: rtl/coin_debounce.sv
// coin_debounce: 2-flop synchroniser, stability counter and rising-edge pulse for one sensor
module coin_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic c,
    input  logic r,
    input  logic raw,
    output logic rise
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d, upd;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        upd     = sync2_q != deb_q && cnt_q == CW'(DEB_CYCLES - 1);
        cnt_d   = (sync2_q == deb_q || upd) ? '0 : cnt_q + CW'(1);
        deb_d   = upd ? sync2_q : deb_q;
        rise    = upd & sync2_q;
    end
    always_ff @(posedge c) begin
        if (r) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounced coin sensors -> event FIFO -> {e2,e1} valid/ready stream.
// Define COIN_ACCEPTOR_TOTAL_EN to add the saturating credit_total counter with clr_total.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic c,
    input  logic r,
    input  logic coin_a_raw,
    input  logic coin_b_raw,
    coin_acceptor_if.master o,
    output logic overflow
`ifdef COIN_ACCEPTOR_TOTAL_EN
    ,
    input  logic       clr_total,
    output logic [7:0] credit_total
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic rise_a, rise_b, empty, full, pop, push, ovf_q, ovf_d;
    logic [1:0] code;
    logic [1:0] mem_q [FIFO_DEPTH];
    logic [1:0] mem_d [FIFO_DEPTH];
    logic [AW:0] wp_q, wp_d, rp_q, rp_d;
    coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (.c(c), .r(r), .raw(coin_a_raw), .rise(rise_a));
    coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (.c(c), .r(r), .raw(coin_b_raw), .rise(rise_b));
    // A full FIFO still accepts a push when the head leaves on the same edge
    always_comb begin
        code  = {rise_b, rise_a};
        empty = wp_q == rp_q;
        full  = wp_q[AW] != rp_q[AW] && wp_q[AW-1:0] == rp_q[AW-1:0];
        pop   = !empty && o.out_ready;
        push  = code != COIN_NONE && (!full || pop);
        mem_d = mem_q;
        if (push) mem_d[wp_q[AW-1:0]] = code;
        wp_d  = wp_q + (AW+1)'(push);
        rp_d  = rp_q + (AW+1)'(pop);
        ovf_d = ovf_q | (code != COIN_NONE && full && !pop);
    end
    always_ff @(posedge c) begin
        if (r) begin
            mem_q <= '{default: '0};
            wp_q  <= '0;
            rp_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            ovf_q <= ovf_d;
        end
    end
    assign o.out_valid    = !empty;
    assign {o.e2, o.e1}   = empty ? COIN_NONE : mem_q[rp_q[AW-1:0]];
    assign overflow       = ovf_q;
`ifdef COIN_ACCEPTOR_TOTAL_EN
    logic [7:0] total_q, total_d;
    always_comb total_d = clr_total ? 8'd0 : push ? coin_add(total_q, code) : total_q;
    always_ff @(posedge c) total_q <= r ? 8'd0 : total_d;
    assign credit_total = total_q;
`endif
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: table vectors, directed corner sequences and a randomized run against a
// queue-based reference model of the coin acceptor.
module tb_coin_acceptor;
    localparam int DEB = 4;
    localparam int DEPTH = 4;
    localparam int NRND = 3000;
    logic c = 1'b0, r = 1'b1, ca = 1'b0, cb = 1'b0, overflow;
    int checks = 0, failures = 0;
    coin_acceptor_if u_if ();
`ifdef COIN_ACCEPTOR_TOTAL_EN
    logic clr_total = 1'b0;
    logic [7:0] credit_total;
`endif
    coin_acceptor #(.DEB_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
        .c(c), .r(r), .coin_a_raw(ca), .coin_b_raw(cb), .o(u_if), .overflow(overflow)
`ifdef COIN_ACCEPTOR_TOTAL_EN
        , .clr_total(clr_total), .credit_total(credit_total)
`endif
    );
    always #5 c = ~c;

    typedef struct {bit a; bit b; int exp;} vec_t;
    vec_t tbl[6];

    bit hist[2][4096];
    bit mdeb[2];
    int mlast[2];
    int mq[$];
    bit movf;
    int mtot;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask
    task automatic tick();
        @(posedge c);
        #1;
    endtask
    task automatic do_reset();
        r = 1'b1;
        repeat (3) tick();
        r = 1'b0;
    endtask
    task automatic press(input bit pa, input bit pb, input int hi, input int lo);
        ca = pa;
        cb = pb;
        repeat (hi) tick();
        ca = 1'b0;
        cb = 1'b0;
        repeat (lo) tick();
    endtask
    function automatic int head();
        return {u_if.e2, u_if.e1};
    endfunction

    // Synced sample at edge k is the raw level sampled two edges earlier
    function automatic bit synced(input int ch, input int k);
        return k >= 3 ? hist[ch][k-3] : 1'b0;
    endfunction
    // Level flips once DEB fresh synced samples all disagree with it; returns 1 on a 0->1 flip
    function automatic bit step(input int ch, input int t);
        bit diff = 1'b1;
        if (t - mlast[ch] < DEB) return 1'b0;
        for (int k = t - DEB + 1; k <= t; k++) if (synced(ch, k) == mdeb[ch]) diff = 1'b0;
        if (!diff) return 1'b0;
        mdeb[ch] = !mdeb[ch];
        mlast[ch] = t;
        return mdeb[ch];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int ra, rb, rr, code, w;
        bit ea, eb;
        int exp5[4] = '{1, 1, 1, 2};
        tbl[0] = '{1'b1, 1'b0, 1};
        tbl[1] = '{1'b0, 1'b1, 2};
        tbl[2] = '{1'b1, 1'b1, 3};
        tbl[3] = '{1'b0, 1'b1, 2};
        tbl[4] = '{1'b1, 1'b0, 1};
        tbl[5] = '{1'b1, 1'b1, 3};
        u_if.out_ready = 1'b0;
        // reset with A held high, then exactly 6 cycles to the first event
        ca = 1'b1;
        r = 1'b1;
        repeat (3) tick();
        chk("rst_valid", u_if.out_valid, 0);
        chk("rst_code", head(), 0);
        chk("rst_ovf", overflow, 0);
        r = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("lat_early_valid", u_if.out_valid, 0);
        end
        tick();
        chk("lat_valid", u_if.out_valid, 1);
        chk("lat_code", head(), 1);
        ca = 1'b0;
        u_if.out_ready = 1'b1;
        tick();
        u_if.out_ready = 1'b0;
        chk("lat_popped", u_if.out_valid, 0);
        repeat (8) tick();
        // encoding table
        for (int i = 0; i < 6; i++) begin
            press(tbl[i].a, tbl[i].b, 8, 8);
            chk("tbl_valid", u_if.out_valid, 1);
            chk("tbl_code", head(), tbl[i].exp);
            u_if.out_ready = 1'b1;
            tick();
            u_if.out_ready = 1'b0;
            chk("tbl_empty", u_if.out_valid, 0);
        end
        // short B glitches, then one long press
        for (int wd = 1; wd <= 3; wd++) begin
            press(1'b0, 1'b1, wd, 3);
            chk("glitch_none", u_if.out_valid, 0);
        end
        cb = 1'b1;
        repeat (10) tick();
        chk("b_valid", u_if.out_valid, 1);
        chk("b_code", head(), 2);
        cb = 1'b0;
        repeat (10) tick();
        u_if.out_ready = 1'b1;
        tick();
        u_if.out_ready = 1'b0;
        chk("b_single_event", u_if.out_valid, 0);
        // simultaneous A and B
        press(1'b1, 1'b1, 10, 10);
        chk("jam_code", head(), 3);
        u_if.out_ready = 1'b1;
        tick();
        u_if.out_ready = 1'b0;
        chk("jam_single", u_if.out_valid, 0);
        // overflow
        for (int i = 0; i < 5; i++) begin
            press(1'b1, 1'b0, 8, 8);
            chk("ovf_flag", overflow, i == 4 ? 1 : 0);
        end
        u_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain_valid", u_if.out_valid, 1);
            chk("ovf_drain_code", head(), 1);
            tick();
        end
        u_if.out_ready = 1'b0;
        chk("ovf_drained", u_if.out_valid, 0);
        chk("ovf_sticky", overflow, 1);
        // push and pop on the same edge while full
        do_reset();
        chk("reset_clears_ovf", overflow, 0);
        repeat (4) press(1'b1, 1'b0, 8, 8);
        cb = 1'b1;
        repeat (5) tick();
        u_if.out_ready = 1'b1;
        tick();
        u_if.out_ready = 1'b0;
        cb = 1'b0;
        chk("fullpp_ovf", overflow, 0);
        u_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("fullpp_valid", u_if.out_valid, 1);
            chk("fullpp_order", head(), exp5[i]);
            tick();
        end
        u_if.out_ready = 1'b0;
        chk("fullpp_empty", u_if.out_valid, 0);
        repeat (8) tick();
`ifdef COIN_ACCEPTOR_TOTAL_EN
        do_reset();
        chk("tot_reset", credit_total, 0);
        u_if.out_ready = 1'b1;
        press(1'b1, 1'b0, 8, 8);
        press(1'b0, 1'b1, 8, 8);
        press(1'b1, 1'b1, 8, 8);
        chk("tot_abj", credit_total, 3);
        repeat (130) press(1'b0, 1'b1, 7, 7);
        chk("tot_sat", credit_total, 255);
        clr_total = 1'b1;
        tick();
        clr_total = 1'b0;
        chk("tot_clr", credit_total, 0);
        u_if.out_ready = 1'b0;
`endif
        // randomized run against the reference model
        do_reset();
        mdeb = '{1'b0, 1'b0};
        mlast = '{0, 0};
        mq.delete();
        movf = 1'b0;
        mtot = 0;
        ra = 0;
        rb = 0;
        rr = 0;
        for (int t = 1; t <= NRND; t++) begin
            if (ra == 0) begin ca = 1'($urandom_range(0, 1)); ra = $urandom_range(1, 10); end
            if (rb == 0) begin cb = 1'($urandom_range(0, 1)); rb = $urandom_range(1, 10); end
            if (rr == 0) begin u_if.out_ready = 1'($urandom_range(0, 1)); rr = $urandom_range(1, 30); end
            ra--;
            rb--;
            rr--;
            hist[0][t-1] = ca;
            hist[1][t-1] = cb;
            ea = step(0, t);
            eb = step(1, t);
            code = {30'd0, eb, ea};
            if (mq.size() > 0 && u_if.out_ready) void'(mq.pop_front());
            if (code != 0) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(code);
                    w = code == 1 ? 1 : code == 2 ? 2 : 0;
                    mtot = mtot + w > 255 ? 255 : mtot + w;
                end else movf = 1'b1;
            end
            tick();
            chk("rnd_valid", u_if.out_valid, mq.size() > 0 ? 1 : 0);
            chk("rnd_code", head(), mq.size() > 0 ? mq[0] : 0);
            chk("rnd_ovf", overflow, movf);
`ifdef COIN_ACCEPTOR_TOTAL_EN
            chk("rnd_total", credit_total, mtot);
`endif
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
